// File: rtl/control_address_sequencer_pkg.sv
// Shared control-unit constants: next-address source encodings used by both the
// next-state address selector and the control address sequencer.
package control_address_sequencer_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_ENCODER = 2'b00;
  localparam sel_t SEL_FETCH   = 2'b01;
  localparam sel_t SEL_CR      = 2'b10;
  localparam sel_t SEL_INCR    = 2'b11;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/control_address_sequencer_if.sv
// Sequencer control bus: address sources and hold come in, microaddress and
// timeout status go out.
interface control_address_sequencer_if
  import control_address_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
);
  sel_t              mux_select;
  logic [ADDR_W-1:0] encoder_addr;
  logic [ADDR_W-1:0] cr_addr;
  logic              hold;
  logic [ADDR_W-1:0] state;
  logic [ADDR_W-1:0] incr_addr;
  logic              wait_timeout;

  modport master (
    output mux_select, encoder_addr, cr_addr, hold,
    input  state, incr_addr, wait_timeout
  );

  modport slave (
    input  mux_select, encoder_addr, cr_addr, hold,
    output state, incr_addr, wait_timeout
  );
endinterface

// File: rtl/control_address_sequencer_next_address_mux.sv
// 4:1 next-microaddress selector; purely combinational, registered by the caller.
module next_address_mux
  import control_address_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FETCH_ADDR = 1
) (
  input  sel_t              sel,
  input  logic [ADDR_W-1:0] encoder_addr,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] incr_addr,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);

  always_comb begin
    next_addr = incr_addr;
    unique case (sel)
      SEL_ENCODER: next_addr = encoder_addr;
      SEL_FETCH:   next_addr = FETCH_A;
      SEL_CR:      next_addr = cr_addr;
      SEL_INCR:    next_addr = incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end
endmodule

// File: rtl/control_address_sequencer.sv
// Microprogram address sequencer: registered microaddress and incrementer, with a
// hold-driven wait counter that raises a sticky timeout flag.
module control_address_sequencer
  import control_address_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RESET_ADDR = 0,
  parameter int FETCH_ADDR = 1,
  parameter int MAX_WAIT   = 15
) (
  input logic                       clk,
  input logic                       reset,
  control_address_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  logic [ADDR_W-1:0] state_q, incr_q, next_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  next_address_mux #(
    .ADDR_W     (ADDR_W),
    .FETCH_ADDR (FETCH_ADDR)
  ) u_mux (
    .sel          (bus.mux_select),
    .encoder_addr (bus.encoder_addr),
    .cr_addr      (bus.cr_addr),
    .incr_addr    (incr_q),
    .next_addr    (next_addr)
  );

  // Incrementer wraps naturally at ADDR_W bits; the timeout flag never stalls sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_A;
      incr_q    <= RST_A + ONE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (bus.hold) begin
      if (wait_cnt == MAX_W) timeout_q <= 1'b1;
      else                   wait_cnt  <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
      state_q  <= next_addr;
      incr_q   <= next_addr + ONE;
    end
  end

  assign bus.state        = state_q;
  assign bus.incr_addr    = incr_q;
  assign bus.wait_timeout = timeout_q;
endmodule

// File: tb/tb_control_address_sequencer.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares
// after every rising edge.
module tb_control_address_sequencer;
  localparam int AW = 8;
  localparam int RST_ADDR = 0;
  localparam int FETCH = 1;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_address_sequencer_if #(.ADDR_W(AW)) bus();

  control_address_sequencer #(
    .ADDR_W(AW), .RESET_ADDR(RST_ADDR), .FETCH_ADDR(FETCH), .MAX_WAIT(MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned st;
    int unsigned inc;
    bit          to;
    int unsigned id;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int unsigned issued = 0;

  // Reference model state (plain integers)
  int unsigned m_state, m_incr, m_wait;
  bit m_to;

  function automatic void model_step(bit r, int unsigned s, int unsigned e, int unsigned c, bit h);
    int unsigned src[4];
    if (r) begin
      m_state = RST_ADDR % 256;
      m_incr  = (RST_ADDR + 1) % 256;
      m_wait  = 0;
      m_to    = 1'b0;
    end else if (h) begin
      if (m_wait >= MAXW) m_to = 1'b1;
      else m_wait = m_wait + 1;
    end else begin
      src[0] = e; src[1] = FETCH; src[2] = c; src[3] = m_incr;
      m_state = src[s];
      m_incr  = (m_state + 1) % 256;
      m_wait  = 0;
    end
  endfunction

  task automatic cyc(input bit r, input int unsigned s, input int unsigned e,
                     input int unsigned c, input bit h);
    exp_t x;
    @(negedge clk);
    reset            = r;
    bus.mux_select   = s[1:0];
    bus.encoder_addr = e[7:0];
    bus.cr_addr      = c[7:0];
    bus.hold         = h;
    model_step(r, s, e, c, h);
    x.st = m_state; x.inc = m_incr; x.to = m_to; x.id = issued;
    issued++;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        vectors++;
        if (bus.state !== x.st[7:0] || bus.incr_addr !== x.inc[7:0] || bus.wait_timeout !== x.to) begin
          miscompares++;
          $display("FAIL vec%0d state/incr/timeout: got %02h/%02h/%0b expected %02h/%02h/%0b",
                   x.id, bus.state, bus.incr_addr, bus.wait_timeout, x.st[7:0], x.inc[7:0], x.to);
        end
      end
    end
  end

  initial begin : stim
    int unsigned hl;
    bus.mux_select = 2'b00; bus.encoder_addr = '0; bus.cr_addr = '0; bus.hold = 1'b0;
    m_state = 0; m_incr = 1; m_wait = 0; m_to = 0;
    // reset then count up
    cyc(1, 3, 0, 0, 0);
    cyc(1, 1, 8'h55, 8'hAA, 1);
    for (int i = 0; i < 4; i++) cyc(0, 3, $urandom_range(255), $urandom_range(255), 0);
    // encoder and control-register sources
    cyc(0, 2, 0, 8'h05, 0);
    cyc(0, 0, 8'h3C, 8'h11, 0);
    cyc(0, 2, 8'h22, 8'h80, 0);
    // wrap at all-ones
    cyc(0, 2, 0, 8'hFE, 0);
    cyc(0, 3, 0, 0, 0);
    cyc(0, 3, 0, 0, 0);
    // short hold with toggling select, then fetch
    cyc(0, 2, 0, 8'h10, 0);
    for (int i = 0; i < 3; i++) cyc(0, i, $urandom_range(255), $urandom_range(255), 1);
    cyc(0, 1, 8'h77, 8'h99, 0);
    // hold through timeout, flag sticky, then reset clears
    for (int i = 0; i < 16; i++) cyc(0, $urandom_range(3), 8'h33, 8'h44, 1);
    cyc(0, 3, 0, 0, 0);
    cyc(0, 0, 8'h20, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 3, 0, 0, 0);
    // reset and hold together
    cyc(0, 2, 0, 8'h42, 0);
    cyc(1, 3, 0, 0, 1);
    cyc(0, 3, 0, 0, 0);
    // hold exactly MAXW cycles: no timeout yet; release clears count
    for (int i = 0; i < MAXW; i++) cyc(0, 3, 0, 0, 1);
    cyc(0, 3, 0, 0, 0);
    for (int i = 0; i < MAXW; i++) cyc(0, 3, 0, 0, 1);
    cyc(0, 3, 0, 0, 0);
    // randomized traffic with occasional long holds and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 5) begin
        hl = $urandom_range(20, 10);
        for (int k = 0; k < hl; k++)
          cyc(0, $urandom_range(3), $urandom_range(255), $urandom_range(255), 1);
      end else begin
        cyc($urandom_range(99) < 3, $urandom_range(3), $urandom_range(255),
            $urandom_range(255), $urandom_range(99) < 30);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
